// File: rtl/halut_encoder_pkg.sv
// Shared types and helpers for the HALUT stream encoder: FSM states, fp16 compare, node offset.
package halut_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    HOLD
  } enc_state_e;

  // Strict fp16 greater-than: signed zeros compare equal, any NaN yields 0.
  function automatic logic fp16_gt(input logic [15:0] a, input logic [15:0] b);
    logic a_nan;
    logic b_nan;
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'h000);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'h000);
    if (a_nan || b_nan) return 1'b0;
    if ((a[14:0] == 15'h0) && (b[14:0] == 15'h0)) return 1'b0;
    if (a[15] != b[15]) return b[15];
    if (!a[15]) return (a[14:0] > b[14:0]);
    return (a[14:0] < b[14:0]);
  endfunction

  function automatic int node_offset(input int level);
    return (1 << level) - 1;
  endfunction

endpackage

// File: rtl/halut_thresh_mem.sv
// Per-unit threshold storage: flop array, one combinational read port, one write port.
// Contents are not reset; a write lands at the clock edge so a same-cycle read sees the old value.
module halut_thresh_mem #(
  parameter int Depth     = 128,
  parameter int AddrWidth = 7,
  parameter int DataWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/halut_encoder_stream.sv
// HALUT encoder unit: walks a TreeDepth-level decision tree one level per cycle, code valid TreeDepth cycles after accept,
// a busy output slot parks the finished code in HOLD. Define HALUT_ENCODER_STATS_EN to add the enc_count_o transfer counter.
module halut_encoder_stream
  import halut_encoder_pkg::*;
#(
  parameter int K                  = 16,
  parameter int C                  = 32,
  parameter int EncUnits           = 4,
  parameter int DataTypeWidth      = 16,
  parameter int EncUnitNumber      = 0,
  parameter int TreeDepth          = $clog2(K),
  parameter int CAddrWidth         = $clog2(C),
  parameter int CPerEncUnit        = C / EncUnits,
  parameter int ThreshMemAddrWidth = $clog2(CPerEncUnit * K)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [TreeDepth*DataTypeWidth-1:0] a_input_i,
  input  logic [ThreshMemAddrWidth-1:0]      waddr_i,
  input  logic [DataTypeWidth-1:0]           wdata_i,
  input  logic                               we_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [TreeDepth-1:0]               k_addr_o,
`ifdef HALUT_ENCODER_STATS_EN
  output logic [31:0]                        enc_count_o,
`endif
  output logic [CAddrWidth-1:0]              c_addr_o
);

  localparam int LvlW = (TreeDepth > 1) ? $clog2(TreeDepth) : 1;
  localparam int ClW  = (CPerEncUnit > 1) ? $clog2(CPerEncUnit) : 1;

  enc_state_e                         state_q, state_d;
  logic [LvlW-1:0]                    level_q, level_d;
  logic [TreeDepth-1:0]               k_q, k_d;
  logic [ClW-1:0]                     cl_q, cl_d;
  logic [TreeDepth*DataTypeWidth-1:0] a_q, a_d;
  logic                               out_valid_q, out_valid_d;
  logic [TreeDepth-1:0]               k_out_q, k_out_d;
  logic [CAddrWidth-1:0]              c_out_q, c_out_d;

  logic [ThreshMemAddrWidth-1:0] raddr;
  logic [DataTypeWidth-1:0]      thr;
  logic [DataTypeWidth-1:0]      a_elem;
  logic                          cmp_bit;
  logic [TreeDepth-1:0]          k_next;
  logic [ClW-1:0]                cl_next;
  logic [CAddrWidth-1:0]         c_glob;
  logic                          slot_free;
  logic                          last_lvl;

  assign raddr   = ThreshMemAddrWidth'(int'(cl_q) * K + node_offset(int'(level_q)) + int'(k_q));
  assign a_elem  = a_q[int'(level_q)*DataTypeWidth +: DataTypeWidth];
  assign cmp_bit = fp16_gt(a_elem, thr);
  assign k_next  = TreeDepth'({k_q, cmp_bit});
  assign cl_next = (cl_q == ClW'(CPerEncUnit - 1)) ? '0 : cl_q + 1'b1;
  assign c_glob  = CAddrWidth'(EncUnitNumber + EncUnits * int'(cl_q));
  assign slot_free = !out_valid_q || out_ready_i;
  assign last_lvl  = (level_q == LvlW'(TreeDepth - 1));

  halut_thresh_mem #(
    .Depth    (CPerEncUnit * K),
    .AddrWidth(ThreshMemAddrWidth),
    .DataWidth(DataTypeWidth)
  ) u_thresh_mem (
    .clk_i  (clk_i),
    .we_i   (we_i),
    .waddr_i(waddr_i),
    .wdata_i(wdata_i),
    .raddr_i(raddr),
    .rdata_o(thr)
  );

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    k_d         = k_q;
    cl_d        = cl_q;
    a_d         = a_q;
    out_valid_d = out_valid_q;
    k_out_d     = k_out_q;
    c_out_d     = c_out_q;
    in_ready_o  = (state_q == IDLE);

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_input_i;
          level_d = '0;
          k_d     = '0;
          state_d = WALK;
        end
      end
      WALK: begin
        k_d     = k_next;
        level_d = level_q + 1'b1;
        if (last_lvl) begin
          if (slot_free) begin
            k_out_d     = k_next;
            c_out_d     = c_glob;
            out_valid_d = 1'b1;
            cl_d        = cl_next;
            state_d     = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // k_q already carries the finished code
        if (slot_free) begin
          k_out_d     = k_q;
          c_out_d     = c_glob;
          out_valid_d = 1'b1;
          cl_d        = cl_next;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d     = IDLE;
      level_d     = '0;
      k_d         = '0;
      cl_d        = '0;
      out_valid_d = 1'b0;
      k_out_d     = '0;
      c_out_d     = CAddrWidth'(EncUnitNumber);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      level_q     <= '0;
      k_q         <= '0;
      cl_q        <= '0;
      a_q         <= '0;
      out_valid_q <= 1'b0;
      k_out_q     <= '0;
      c_out_q     <= CAddrWidth'(EncUnitNumber);
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      k_q         <= k_d;
      cl_q        <= cl_d;
      a_q         <= a_d;
      out_valid_q <= out_valid_d;
      k_out_q     <= k_out_d;
      c_out_q     <= c_out_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign k_addr_o    = k_out_q;
  assign c_addr_o    = c_out_q;

`ifdef HALUT_ENCODER_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) cnt_d = '0;
    else if (out_valid_q && out_ready_i && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign enc_count_o = cnt_q;
`endif

endmodule
